// File: rtl/psd_div_sched_if.sv
// psd_div_sched_if: requester-side and divider-side signals of the two-channel divider scheduler.
interface psd_div_sched_if;
   logic        req0, req1, ack0, ack1, done0, done1, dz0, dz1, busy;
   logic        div_start, div_stop;
   logic [31:0] dividend0, dividend1, quotient0, quotient1, div_dividend, div_quotient;
   logic [15:0] divisor0, divisor1, rest0, rest1, div_divisor, div_rest;
   modport slave (
      input  req0, req1, dividend0, dividend1, divisor0, divisor1, div_quotient, div_rest,
      output ack0, ack1, done0, done1, dz0, dz1, busy, quotient0, quotient1, rest0, rest1,
             div_start, div_stop, div_dividend, div_divisor
   );
   modport master (
      output req0, req1, dividend0, dividend1, divisor0, divisor1, div_quotient, div_rest,
      input  ack0, ack1, done0, done1, dz0, dz1, busy, quotient0, quotient1, rest0, rest1,
             div_start, div_stop, div_dividend, div_divisor
   );
endinterface

// File: rtl/psd_div_sched.sv
// psd_div_sched: round-robin sharing of one sequential 32/16 divider between two channels.
// Define PSD_DIVZERO_EN to short-circuit divisor-0 requests through a one-cycle ZERO state.
module psd_div_sched (
   input logic            clock,
   input logic            reset,
   psd_div_sched_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, START, RUN, STOP, CAPT
`ifdef PSD_DIVZERO_EN
      , ZERO
`endif
   } state_t;
   state_t      state_q, state_d;
   logic        prio_q, prio_d, owner_q, owner_d, sel, acc;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d, quo0_q, quo0_d, quo1_q, quo1_d;
   logic [15:0] dvs_q, dvs_d, rem0_q, rem0_d, rem1_q, rem1_d, sel_dvs;
   logic        done0_q, done0_d, done1_q, done1_d;
`ifdef PSD_DIVZERO_EN
   logic        dz0_q, dz0_d, dz1_q, dz1_d;
   assign acc = (state_q == START) || (state_q == ZERO);
   assign bus.dz0 = dz0_q;
   assign bus.dz1 = dz1_q;
`else
   assign acc = state_q == START;
   assign bus.dz0 = 1'b0;
   assign bus.dz1 = 1'b0;
`endif
   // a lone requester wins outright; prio only breaks ties
   assign sel     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
   assign sel_dvs = sel ? bus.divisor1 : bus.divisor0;
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo0_d  = quo0_q;
      quo1_d  = quo1_q;
      rem0_d  = rem0_q;
      rem1_d  = rem1_q;
      done0_d = 1'b0;
      done1_d = 1'b0;
`ifdef PSD_DIVZERO_EN
      dz0_d   = dz0_q;
      dz1_d   = dz1_q;
`endif
      unique case (state_q)
         IDLE: if (bus.req0 || bus.req1) begin
            owner_d = sel;
            dvd_d   = sel ? bus.dividend1 : bus.dividend0;
            dvs_d   = sel_dvs;
`ifdef PSD_DIVZERO_EN
            state_d = (sel_dvs == 16'd0) ? ZERO : START;
`else
            state_d = START;
`endif
         end
         START: begin
            cnt_d   = 5'd0;
            state_d = RUN;
         end
         RUN: begin
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd31) ? STOP : RUN;
         end
         STOP: state_d = CAPT;
         CAPT: begin
            quo0_d  = owner_q ? quo0_q : bus.div_quotient;
            rem0_d  = owner_q ? rem0_q : bus.div_rest;
            quo1_d  = owner_q ? bus.div_quotient : quo1_q;
            rem1_d  = owner_q ? bus.div_rest : rem1_q;
            done0_d = !owner_q;
            done1_d = owner_q;
`ifdef PSD_DIVZERO_EN
            dz0_d   = owner_q ? dz0_q : 1'b0;
            dz1_d   = owner_q ? 1'b0 : dz1_q;
`endif
            prio_d  = !owner_q;
            state_d = IDLE;
         end
`ifdef PSD_DIVZERO_EN
         ZERO: begin
            quo0_d  = owner_q ? quo0_q : 32'd0;
            rem0_d  = owner_q ? rem0_q : 16'd0;
            quo1_d  = owner_q ? 32'd0 : quo1_q;
            rem1_d  = owner_q ? 16'd0 : rem1_q;
            done0_d = !owner_q;
            done1_d = owner_q;
            dz0_d   = owner_q ? dz0_q : 1'b1;
            dz1_d   = owner_q ? 1'b1 : dz1_q;
            prio_d  = !owner_q;
            state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         cnt_q   <= 5'd0;
         dvd_q   <= 32'd0;
         dvs_q   <= 16'd0;
         quo0_q  <= 32'd0;
         quo1_q  <= 32'd0;
         rem0_q  <= 16'd0;
         rem1_q  <= 16'd0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
`ifdef PSD_DIVZERO_EN
         dz0_q   <= 1'b0;
         dz1_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo0_q  <= quo0_d;
         quo1_q  <= quo1_d;
         rem0_q  <= rem0_d;
         rem1_q  <= rem1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
`ifdef PSD_DIVZERO_EN
         dz0_q   <= dz0_d;
         dz1_q   <= dz1_d;
`endif
      end
   end
   assign bus.ack0         = acc && !owner_q;
   assign bus.ack1         = acc && owner_q;
   assign bus.busy         = state_q != IDLE;
   assign bus.div_start    = state_q == START;
   assign bus.div_stop     = state_q == STOP;
   assign bus.div_dividend = dvd_q;
   assign bus.div_divisor  = dvs_q;
   assign bus.done0        = done0_q;
   assign bus.done1        = done1_q;
   assign bus.quotient0    = quo0_q;
   assign bus.quotient1    = quo1_q;
   assign bus.rest0        = rem0_q;
   assign bus.rest1        = rem1_q;
endmodule

// File: tb/tb_psd_div_sched.sv
// tb_psd_div_sched: directed scenarios against a behavioural divider whose outputs are only valid in the capture cycle.
module tb_psd_div_sched;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   psd_div_sched_if bus ();
   psd_div_sched dut (.clock(clock), .reset(reset), .bus(bus.slave));

   typedef struct {
      logic        ch;
      logic [31:0] q;
      logic [15:0] r;
      logic        dz;
   } exp_t;
   exp_t        sb[$];
   int          total = 0, bad = 0, cyc = 0, n_start = 0;
   logic [31:0] last_q[2];
   logic [15:0] last_r[2];

   always @(posedge clock) cyc <= cyc + 1;

   // divider stand-in: operands latched at start, result driven only the cycle after stop
   logic [31:0] m_dvd = 32'd0, m_q;
   logic [15:0] m_dvs = 16'd0, m_r;
   logic        m_valid = 1'b0;
   function automatic logic [47:0] ref_div(input logic [31:0] a, input logic [15:0] d);
      longint sa, ua, uq, ur;
      logic [31:0] q;
      sa = longint'($signed(a));
      ua = sa < 0 ? -sa : sa;
      uq = d == 16'd0 ? 64'hFFFF_FFFF : ua / longint'(d);
      ur = d == 16'd0 ? (ua & 64'hFFFF) : ua % longint'(d);
      q  = sa < 0 ? 32'(-uq) : 32'(uq);
      return {16'(ur), q};
   endfunction
   always @(posedge clock) begin
      m_valid <= reset ? 1'b0 : bus.div_stop;
      if (bus.div_start) begin
         m_dvd   <= bus.div_dividend;
         m_dvs   <= bus.div_divisor;
         n_start <= n_start + 1;
      end
   end
   assign {m_r, m_q} = ref_div(m_dvd, m_dvs);
   assign bus.div_quotient = m_valid ? m_q : 32'hDEAD_BEEF;
   assign bus.div_rest     = m_valid ? m_r : 16'hBEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {23'd0, bus.ack0, bus.ack1, bus.done0, bus.done1, bus.dz0, bus.dz1,
                          bus.busy, bus.div_start, bus.div_stop}, 32'd0);
      chk({tag, "_dvd"}, bus.div_dividend, 32'd0);
      chk({tag, "_dvs"}, {16'd0, bus.div_divisor}, 32'd0);
      chk({tag, "_q0"}, bus.quotient0, 32'd0);
      chk({tag, "_q1"}, bus.quotient1, 32'd0);
      chk({tag, "_rest"}, {bus.rest0, bus.rest1}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk_zero("rst");
      reset = 1'b0;
      sb.delete();
      last_q = '{32'd0, 32'd0};
      last_r = '{16'd0, 16'd0};
   endtask

   task automatic drive(input logic ch, input logic [31:0] a, input logic [15:0] d);
      if (ch) begin bus.req1 = 1'b1; bus.dividend1 = a; bus.divisor1 = d; end
      else    begin bus.req0 = 1'b1; bus.dividend0 = a; bus.divisor0 = d; end
   endtask

   task automatic push(input logic ch, input logic [31:0] q, input logic [15:0] r, input logic dz);
      exp_t e;
      e.ch = ch; e.q = q; e.r = r; e.dz = dz;
      sb.push_back(e);
   endtask

   task automatic wait_done(input int exp_at);
      exp_t e;
      for (int i = 0; i < 200 && !(bus.done0 || bus.done1); i++) @(negedge clock);
      if (!(bus.done0 || bus.done1)) begin
         total++; bad++;
         $error("FAIL done_timeout observed=no done expected=done at cycle %0d", exp_at);
         return;
      end
      if (sb.size() == 0) begin
         total++; bad++;
         $error("FAIL sb_empty observed=unexpected done expected=none");
         return;
      end
      e = sb.pop_front();
      chk("done_ch", {31'd0, bus.done1}, {31'd0, e.ch});
      chk("done_both", {31'd0, bus.done0 & bus.done1}, 32'd0);
      chk("done_cyc", cyc, exp_at);
      chk("busy_done", {31'd0, bus.busy}, 32'd0);
      chk("quo", e.ch ? bus.quotient1 : bus.quotient0, e.q);
      chk("rest", {16'd0, e.ch ? bus.rest1 : bus.rest0}, {16'd0, e.r});
      chk("dz", {31'd0, e.ch ? bus.dz1 : bus.dz0}, {31'd0, e.dz});
      chk("quo_other", e.ch ? bus.quotient0 : bus.quotient1, last_q[!e.ch]);
      chk("rest_other", {16'd0, e.ch ? bus.rest0 : bus.rest1}, {16'd0, last_r[!e.ch]});
      last_q[e.ch] = e.q;
      last_r[e.ch] = e.r;
   endtask

   task automatic op(input logic ch, input logic [31:0] a, input logic [15:0] d,
                     input logic [31:0] q, input logic [15:0] r, input logic dz, input int lat);
      int t0;
      @(negedge clock);
      drive(ch, a, d);
      push(ch, q, r, dz);
      t0 = cyc;
      @(negedge clock);
      chk("ack", {30'd0, bus.ack1, bus.ack0}, ch ? 32'd2 : 32'd1);
      chk("start", {31'd0, bus.div_start}, {31'd0, lat == 36});
      chk("busy", {31'd0, bus.busy}, 32'd1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      wait_done(t0 + lat);
   endtask

   // both channels request in the same cycle: ch0 must win, ch1 follows on the cycle of done0
   task automatic pair(input logic [31:0] a0, input logic [15:0] d0, input logic [31:0] q0, input logic [15:0] r0,
                       input logic [31:0] a1, input logic [15:0] d1, input logic [31:0] q1, input logic [15:0] r1);
      int t0;
      drive(1'b0, a0, d0);
      drive(1'b1, a1, d1);
      push(1'b0, q0, r0, 1'b0);
      push(1'b1, q1, r1, 1'b0);
      t0 = cyc;
      @(negedge clock);
      chk("pair_ack0", {30'd0, bus.ack1, bus.ack0}, 32'd1);
      bus.req0 = 1'b0;
      wait_done(t0 + 36);
      @(negedge clock);
      chk("pair_ack1", {30'd0, bus.ack1, bus.ack0}, 32'd2);
      bus.req1 = 1'b0;
      wait_done(t0 + 72);
   endtask

   initial begin
      int seen, ns;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.dividend0 = 32'd0; bus.dividend1 = 32'd0;
      bus.divisor0 = 16'd0; bus.divisor1 = 16'd0;
      do_reset();
      op(1'b0, 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 36);
      op(1'b1, 32'hFFFF_FF9C, 16'd7, 32'hFFFF_FFF2, 16'd2, 1'b0, 36);
      do_reset();
      pair(32'd1000, 16'd10, 32'd100, 16'd0, 32'd12345, 16'd100, 32'd123, 16'd45);
      pair(32'hFFFF_FFF9, 16'd2, 32'hFFFF_FFFD, 16'd1, 32'd65536, 16'hFFFF, 32'd1, 16'd1);
      op(1'b0, 32'h7FFF_FFFF, 16'd1, 32'h7FFF_FFFF, 16'd0, 1'b0, 36);
      op(1'b1, 32'h8000_0000, 16'hFFFF, 32'hFFFF_8000, 16'h8000, 1'b0, 36);
      // abort an operation in its 20th cycle
      @(negedge clock);
      drive(1'b0, 32'd1000, 16'd3);
      @(negedge clock);
      bus.req0 = 1'b0;
      repeat (19) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk_zero("midrst");
      reset = 1'b0;
      sb.delete();
      last_q = '{32'd0, 32'd0};
      last_r = '{16'd0, 16'd0};
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         seen = seen | int'(bus.done0 | bus.done1);
      end
      chk("no_done_after_rst", seen, 32'd0);
      op(1'b0, 32'd1000, 16'd3, 32'd333, 16'd1, 1'b0, 36);
      ns = n_start;
`ifdef PSD_DIVZERO_EN
      op(1'b1, 32'd5, 16'd0, 32'd0, 16'd0, 1'b1, 2);
      chk("zero_no_start", n_start - ns, 32'd0);
`else
      op(1'b1, 32'd5, 16'd0, 32'hFFFF_FFFF, 16'd5, 1'b0, 36);
      chk("zero_start", n_start - ns, 32'd1);
`endif
      op(1'b1, 32'd9, 16'd4, 32'd2, 16'd1, 1'b0, 36);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
